// File: rtl/keys_pio_debounced_pkg.sv
// Shared definitions for the debounced key PIO: register offsets and capture edge modes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package keys_pio_debounced_pkg;

    // Register offsets within the 4-word window
    localparam logic [1:0] OFS_DATA        = 2'd0;
    localparam logic [1:0] OFS_IRQMASK     = 2'd2;
    localparam logic [1:0] OFS_EDGECAPTURE = 2'd3;

    // Which debounced transition counts as an edge
    typedef enum logic [1:0] {
        RISING  = 2'd0,
        FALLING = 2'd1,
        ANY     = 2'd2
    } edge_type_e;

    // True when a debounced change to new_level matches the selected edge mode
    function automatic logic edge_match(edge_type_e mode, logic new_level);
        case (mode)
            RISING:  edge_match = new_level;
            FALLING: edge_match = !new_level;
            default: edge_match = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/keys_pio_debounced_if.sv
// Register bus for the key PIO: select, write qualifiers, write data and registered read data.
// Latency: readdata is valid one cycle after address is presented.
// Backpressure: none; the slave accepts every write in the cycle it is presented.
interface keys_pio_debounced_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write, writedata,
        output readdata
    );
endinterface

// File: rtl/keys_debounce_bit.sv
// One key channel: synchronizer, stability counter, debounced level and registered edge pulse.
// Latency: level changes SYNC_STAGES + DEBOUNCE_CYCLES - 1 cycles after a stable input change; pulse coincides with the change.
// Backpressure: none; free-running per clock.
// Ports: clk, reset (sync, active-high), din (async raw key), level (debounced), edge_pulse (1 cycle).
module keys_debounce_bit
    import keys_pio_debounced_pkg::*;
#(
    parameter int         SYNC_STAGES     = 2,
    parameter int         DEBOUNCE_CYCLES = 50000,
    parameter edge_type_e EDGE_TYPE       = FALLING,
    parameter logic       IDLE            = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic edge_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The level flips on the sample where the count would reach DEBOUNCE_CYCLES-1,
    // so the register itself only ever has to hold up to DEBOUNCE_CYCLES-2.
    localparam logic [CW-1:0] LAST_CNT = CW'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   s;
    logic                   differ;
    logic                   hit;

    assign s      = sync[SYNC_STAGES-1];
    assign differ = (s != level);
    assign hit    = differ && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync       <= {SYNC_STAGES{IDLE}};
            cnt        <= '0;
            level      <= IDLE;
            edge_pulse <= 1'b0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], din};
            edge_pulse <= hit && edge_match(EDGE_TYPE, s);
            if (!differ || hit) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (hit) begin
                level <= s;
            end
        end
    end

endmodule

// File: rtl/keys_pio_debounced.sv
// Debounced key PIO: per-channel debounce, DATA/IRQMASK/EDGECAPTURE registers, level irq.
// Latency: readdata and irq are registered, one cycle behind the state they reflect.
// Backpressure: none; writes complete in the cycle chipselect&write are high.
// Ports: clk, reset (sync, active-high), bus (slave register port), in_port (raw keys), irq.
module keys_pio_debounced
    import keys_pio_debounced_pkg::*;
#(
    parameter int               WIDTH           = 2,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter edge_type_e       EDGE_TYPE       = FALLING,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = '1
) (
    input  logic                 clk,
    input  logic                 reset,
    keys_pio_debounced_if.slave  bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] pulse;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] cap_next;
    logic [31:0]      rd_next;
    logic             wr;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        keys_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .EDGE_TYPE       (EDGE_TYPE),
            .IDLE            (IDLE_LEVEL[i])
        ) u_bit (
            .clk        (clk),
            .reset      (reset),
            .din        (in_port[i]),
            .level      (level[i]),
            .edge_pulse (pulse[i])
        );
    end

    if (WIDTH < 32) begin : g_wd_unused
        logic unused_writedata;
        assign unused_writedata = ^bus.writedata[31:WIDTH];
    end

    assign wr      = bus.chipselect && bus.write;
    assign cap_clr = (wr && bus.address == OFS_EDGECAPTURE) ? bus.writedata[WIDTH-1:0] : '0;
    // OR-in the pulse after clearing so a same-cycle capture survives the clear
    assign cap_next = (edge_cap & ~cap_clr) | pulse;

    always_comb begin
        rd_next = '0;
        case (bus.address)
            OFS_DATA:        rd_next[WIDTH-1:0] = level;
            OFS_IRQMASK:     rd_next[WIDTH-1:0] = irq_mask;
            OFS_EDGECAPTURE: rd_next[WIDTH-1:0] = edge_cap;
            default:         rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask     <= '0;
            edge_cap     <= '0;
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            if (wr && bus.address == OFS_IRQMASK) begin
                irq_mask <= bus.writedata[WIDTH-1:0];
            end
            edge_cap     <= cap_next;
            bus.readdata <= rd_next;
            irq          <= |(edge_cap & irq_mask);
        end
    end

endmodule

// File: tb/tb_keys_pio_debounced.sv
// Directed bench for the debounced key PIO (WIDTH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, FALLING, idle 2'b11).
// Latency: inputs are driven and outputs sampled 1ns after each rising edge.
// Backpressure: n/a.
module tb_keys_pio_debounced;
    import keys_pio_debounced_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] in_port;
    logic       irq;
    int         vectors = 0;
    int         miscompares = 0;

    keys_pio_debounced_if bus ();

    keys_pio_debounced #(
        .WIDTH           (2),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .EDGE_TYPE       (FALLING),
        .IDLE_LEVEL      (2'b11)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        tick();
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = '0;
    endtask

    // Present an offset and return what readdata shows one edge later
    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        bus.address = addr;
        tick();
        data = bus.readdata;
    endtask

    initial begin
        logic [31:0] rd;

        reset          = 1'b1;
        in_port        = 2'b11;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = '0;
        repeat (3) tick();
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;

        // Idle levels after reset: no capture, DATA reads the idle level
        bus_read(OFS_DATA, rd);        check("idle_data", rd, 32'h3);
        bus_read(2'd1, rd);            check("reserved", rd, 32'h0);
        bus_read(OFS_IRQMASK, rd);     check("idle_mask", rd, 32'h0);
        repeat (6) tick();
        bus_read(OFS_EDGECAPTURE, rd); check("idle_cap", rd, 32'h0);
        check("idle_irq", {31'b0, irq}, 32'h0);

        // Falling edge on channel 0: level flips on edge 5, readdata on edge 6
        bus.address = OFS_DATA;
        in_port     = 2'b10;
        repeat (5) tick();
        check("fall_data_early", bus.readdata, 32'h3);
        tick();
        check("fall_data", bus.readdata, 32'h2);
        bus_read(OFS_EDGECAPTURE, rd); check("fall_cap", rd, 32'h1);
        tick();
        check("fall_irq_masked", {31'b0, irq}, 32'h0);

        // Unmask: irq follows one cycle after the mask write lands
        bus_write(OFS_IRQMASK, 32'h1);
        check("irq_mask_same", {31'b0, irq}, 32'h0);
        tick();
        check("irq_mask_next", {31'b0, irq}, 32'h1);
        bus_write(OFS_EDGECAPTURE, 32'h1);
        check("irq_clr_same", {31'b0, irq}, 32'h1);
        tick();
        check("irq_clr_next", {31'b0, irq}, 32'h0);
        bus_read(OFS_EDGECAPTURE, rd); check("cap_cleared", rd, 32'h0);

        // Channel 1 chatters with 2-cycle phases: never stable long enough
        bus.address = OFS_DATA;
        for (int i = 0; i < 10; i++) begin
            in_port[1] = ~in_port[1];
            tick();
            tick();
            check("chatter_data", bus.readdata, 32'h2);
        end
        in_port[1] = 1'b1;
        repeat (6) tick();
        check("chatter_data_end", bus.readdata, 32'h2);
        bus_read(OFS_EDGECAPTURE, rd); check("chatter_cap", rd, 32'h0);

        // Release channel 0 (rising: no capture), then clear racing a new falling pulse
        in_port = 2'b11;
        repeat (8) tick();
        bus_read(OFS_DATA, rd);        check("rise_data", rd, 32'h3);
        bus_read(OFS_EDGECAPTURE, rd); check("rise_cap", rd, 32'h0);
        in_port = 2'b10;
        repeat (5) tick();
        bus_write(OFS_EDGECAPTURE, 32'h1);
        bus_read(OFS_EDGECAPTURE, rd); check("set_beats_clear", rd, 32'h1);
        check("race_irq", {31'b0, irq}, 32'h1);

        // Reset partway through a debounce discards it; fresh debounce after release
        bus_write(OFS_EDGECAPTURE, 32'h3);
        bus_write(OFS_IRQMASK, 32'h3);
        in_port = 2'b11;
        repeat (8) tick();
        bus_read(OFS_EDGECAPTURE, rd); check("pre_rst_cap", rd, 32'h0);
        in_port = 2'b10;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_readdata", bus.readdata, 32'h0);
        check("mid_rst_irq", {31'b0, irq}, 32'h0);
        bus_read(OFS_DATA, rd);        check("post_rst_data", rd, 32'h3);
        bus.address = OFS_EDGECAPTURE;
        repeat (5) tick();
        check("post_rst_cap_early", bus.readdata, 32'h0);
        tick();
        check("post_rst_cap", bus.readdata, 32'h1);
        bus_read(OFS_IRQMASK, rd);     check("post_rst_mask", rd, 32'h0);
        check("post_rst_irq", {31'b0, irq}, 32'h0);
        bus_read(OFS_DATA, rd);        check("post_rst_data_low", rd, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
